jtopl_timer_ctrl: RTL and testbench

CPU-side register front end for the OPL timer pair. Decodes the two-phase address/data host bus, and holds the timer registers 0x02, 0x03 and 0x04. Drives the start values, start bits, masks and flag-clear pulses into the timer block, and returns the status byte built from the timer flags. It also forwards every data write to the rest of the chip and models the chip's write-busy wait.

---
 rtl/jtopl_timer_ctrl_pkg.sv | 38 +++
 rtl/jtopl_timer_ctrl_if.sv | 15 +
 rtl/jtopl_busy_cnt.sv | 31 +++
 rtl/jtopl_timer_ctrl.sv | 130 +++++++++++++
 tb/tb_jtopl_timer_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/jtopl_timer_ctrl_pkg.sv
// Shared constants and types for the OPL timer register front end:
// register addresses, control-byte bit positions and the timer register bundle.
package jtopl_timer_ctrl_pkg;

  localparam logic [7:0] REG_TMR_A    = 8'h02;
  localparam logic [7:0] REG_TMR_B    = 8'h03;
  localparam logic [7:0] REG_TMR_CTRL = 8'h04;

  localparam int CTRL_IRQRST = 7;
  localparam int CTRL_MASKA  = 6;
  localparam int CTRL_MASKB  = 5;
  localparam int CTRL_STB    = 1;
  localparam int CTRL_STA    = 0;

  typedef struct packed {
    logic [7:0] value_a;
    logic [7:0] value_b;
    logic       load_a;
    logic       load_b;
    logic       flagen_a;
    logic       flagen_b;
  } tmr_regs_t;

  // Flags start enabled: a cleared mask register means "unmasked".
  localparam tmr_regs_t TMR_REGS_RST = '{
    value_a:  8'h00,
    value_b:  8'h00,
    load_a:   1'b0,
    load_b:   1'b0,
    flagen_a: 1'b1,
    flagen_b: 1'b1
  };

  function automatic logic wr_edge(input logic req, input logic req_q);
    return req & ~req_q;
  endfunction

endpackage

// File: rtl/jtopl_timer_ctrl_if.sv
// Host bus of the OPL timer front end: two-phase address/data writes,
// status byte read-back and the write-busy indication.
interface jtopl_timer_ctrl_if;
  logic       cs_n;
  logic       wr_n;
  logic       addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       busy;

  modport master (output cs_n, output wr_n, output addr, output din,
                  input dout, input busy);
  modport slave  (input cs_n, input wr_n, input addr, input din,
                  output dout, output busy);
endinterface

// File: rtl/jtopl_busy_cnt.sv
// Loadable down-counter modelling the chip write-wait; decrements on cen
// while non-zero, and a load in the same cycle as cen takes priority.
module jtopl_busy_cnt #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cen,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         busy
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cen && (cnt_q != '0))
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/jtopl_timer_ctrl.sv
// CPU-side register front end for the OPL timer pair (regs 0x02-0x04).
// Optional build macro JTOPL_BUSY_DROP_EN: host writes arriving while busy are discarded.
module jtopl_timer_ctrl
  import jtopl_timer_ctrl_pkg::*;
#(
  parameter int         ADDR_WAIT  = 12,
  parameter int         DATA_WAIT  = 84,
  parameter logic [4:0] STATUS_LOW = 5'h06
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cen,
  jtopl_timer_ctrl_if.slave  host,
  output logic [7:0]         value_A,
  output logic [7:0]         value_B,
  output logic               load_A,
  output logic               load_B,
  output logic               flagen_A,
  output logic               flagen_B,
  output logic               clr_flag_A,
  output logic               clr_flag_B,
  input  logic               flag_A,
  input  logic               flag_B,
  input  logic               irq_n,
  output logic [7:0]         reg_sel,
  output logic [7:0]         reg_din,
  output logic               reg_wr
);

  localparam int CNT_W = $clog2(DATA_WAIT + 1);

  logic             wr_req, wr_req_q;
  logic             take;
  logic             busy;
  logic [CNT_W-1:0] wait_val;

  tmr_regs_t        regs_q, regs_d;
  logic [7:0]       reg_sel_q, reg_sel_d;
  logic [7:0]       reg_din_q, reg_din_d;
  logic             reg_wr_q, reg_wr_d;
  logic             clr_q, clr_d;
  logic [7:0]       dout_q, dout_d;

  assign wr_req = ~host.cs_n & ~host.wr_n;

`ifdef JTOPL_BUSY_DROP_EN
  assign take = wr_edge(wr_req, wr_req_q) & ~busy;
`else
  assign take = wr_edge(wr_req, wr_req_q);
`endif

  assign wait_val = host.addr ? CNT_W'(DATA_WAIT) : CNT_W'(ADDR_WAIT);

  always_comb begin
    regs_d    = regs_q;
    reg_sel_d = reg_sel_q;
    reg_din_d = reg_din_q;
    reg_wr_d  = 1'b0;
    clr_d     = 1'b0;
    dout_d    = {~irq_n, flag_A, flag_B, STATUS_LOW};
    if (take) begin
      if (!host.addr) begin
        reg_sel_d = host.din;
      end else begin
        reg_din_d = host.din;
        reg_wr_d  = 1'b1;
        // Decode uses the address latched by the previous address-phase write.
        case (reg_sel_q)
          REG_TMR_A: regs_d.value_a = host.din;
          REG_TMR_B: regs_d.value_b = host.din;
          REG_TMR_CTRL: begin
            if (host.din[CTRL_IRQRST]) begin
              clr_d = 1'b1;
            end else begin
              regs_d.flagen_a = ~host.din[CTRL_MASKA];
              regs_d.flagen_b = ~host.din[CTRL_MASKB];
              regs_d.load_b   = host.din[CTRL_STB];
              regs_d.load_a   = host.din[CTRL_STA];
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_req_q  <= 1'b0;
      regs_q    <= TMR_REGS_RST;
      reg_sel_q <= 8'h00;
      reg_din_q <= 8'h00;
      reg_wr_q  <= 1'b0;
      clr_q     <= 1'b0;
      dout_q    <= 8'h00;
    end else begin
      wr_req_q  <= wr_req;
      regs_q    <= regs_d;
      reg_sel_q <= reg_sel_d;
      reg_din_q <= reg_din_d;
      reg_wr_q  <= reg_wr_d;
      clr_q     <= clr_d;
      dout_q    <= dout_d;
    end
  end

  jtopl_busy_cnt #(.W(CNT_W)) u_busy_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .load     (take),
    .load_val (wait_val),
    .busy     (busy)
  );

  assign host.busy  = busy;
  assign host.dout  = dout_q;
  assign value_A    = regs_q.value_a;
  assign value_B    = regs_q.value_b;
  assign load_A     = regs_q.load_a;
  assign load_B     = regs_q.load_b;
  assign flagen_A   = regs_q.flagen_a;
  assign flagen_B   = regs_q.flagen_b;
  assign clr_flag_A = clr_q;
  assign clr_flag_B = clr_q;
  assign reg_sel    = reg_sel_q;
  assign reg_din    = reg_din_q;
  assign reg_wr     = reg_wr_q;

endmodule

// File: tb/tb_jtopl_timer_ctrl.sv
// Self-checking bench for jtopl_timer_ctrl: forwarded writes are checked through
// a scoreboard queue, register state, busy timing and status directly.
module tb_jtopl_timer_ctrl;

  typedef struct {
    logic [7:0] sel;
    logic [7:0] din;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b0;
  logic       flag_A = 1'b0;
  logic       flag_B = 1'b0;
  logic       irq_n = 1'b1;
  logic [7:0] value_A, value_B, reg_sel, reg_din;
  logic       load_A, load_B, flagen_A, flagen_B;
  logic       clr_flag_A, clr_flag_B, reg_wr;

  int   total = 0;
  int   bad = 0;
  int   reg_wr_cnt = 0;
  int   clr_a_cnt = 0;
  int   clr_b_cnt = 0;
  logic [7:0] exp_sel = 8'h00;
  exp_t sb[$];

  jtopl_timer_ctrl_if bus ();

  jtopl_timer_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cen        (cen),
    .host       (bus),
    .value_A    (value_A),
    .value_B    (value_B),
    .load_A     (load_A),
    .load_B     (load_B),
    .flagen_A   (flagen_A),
    .flagen_B   (flagen_B),
    .clr_flag_A (clr_flag_A),
    .clr_flag_B (clr_flag_B),
    .flag_A     (flag_A),
    .flag_B     (flag_B),
    .irq_n      (irq_n),
    .reg_sel    (reg_sel),
    .reg_din    (reg_din),
    .reg_wr     (reg_wr)
  );

  always #5 clk = ~clk;

  // cen once every 4 clk, changed just after the rising edge
  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge clk);
      #1;
      cen = (k == 0);
      k = (k + 1) % 4;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reg_wr === 1'b1) begin
      reg_wr_cnt++;
      if (sb.size() == 0) begin
        checkOutput("reg_wr_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("reg_sel", reg_sel, e.sel);
        checkOutput("reg_din", reg_din, e.din);
      end
    end
    if (clr_flag_A === 1'b1) clr_a_cnt++;
    if (clr_flag_B === 1'b1) clr_b_cnt++;
  end

  // Called at a falling edge; strobe held for 'hold' clk, released at a falling edge.
  task automatic applyStimulus(input logic a, input logic [7:0] d, input int hold, input bit accept);
    bus.addr = a;
    bus.din  = d;
    bus.cs_n = 1'b0;
    bus.wr_n = 1'b0;
    if (accept) begin
      if (!a) exp_sel = d;
      else    sb.push_back('{sel: exp_sel, din: d});
    end
    repeat (hold) @(negedge clk);
    bus.cs_n = 1'b1;
    bus.wr_n = 1'b1;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) checkOutput("idle_timeout", bus.busy, 1'b0);
  endtask

  task automatic measureBusy(input int max_ticks, output int ticks);
    int n;
    ticks = 0;
    n = 0;
    while (bus.busy && ticks < max_ticks && n < 3000) begin
      if (cen) ticks++;
      @(negedge clk);
      n++;
    end
    if (n >= 3000) checkOutput("busy_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int t, pre, wr_before;
    bus.cs_n = 1'b1;
    bus.wr_n = 1'b1;
    bus.addr = 1'b0;
    bus.din  = 8'h00;

    repeat (3) @(negedge clk);
    checkOutput("rst_dout", bus.dout, 8'h00);
    checkOutput("rst_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_flagen_A", flagen_A, 1'b1);
    checkOutput("rst_flagen_B", flagen_B, 1'b1);
    checkOutput("rst_values", {value_A, value_B}, 16'h0000);
    checkOutput("rst_loads", {load_A, load_B, clr_flag_A, clr_flag_B}, 4'h0);
    checkOutput("rst_fwd", {reg_sel, reg_din, 7'd0, reg_wr}, 24'h0);
    checkOutput("rst_busy2", bus.busy, 1'b0);
    checkOutput("idle_dout", bus.dout, 8'h06);

    applyStimulus(1'b0, 8'h02, 1, 1'b1);
    measureBusy(1000, t);
    checkOutput("addr_wait_ticks", t, 12);
    waitIdle();
    applyStimulus(1'b1, 8'hA5, 1, 1'b1);
    checkOutput("value_A", value_A, 8'hA5);
    measureBusy(1000, t);
    checkOutput("data_wait_ticks", t, 84);
    waitIdle();

    applyStimulus(1'b0, 8'h03, 1, 1'b1);
    waitIdle();
    applyStimulus(1'b1, 8'h5A, 1, 1'b1);
    checkOutput("value_B", value_B, 8'h5A);
    checkOutput("value_A_kept", value_A, 8'hA5);
    waitIdle();

    applyStimulus(1'b0, 8'h04, 1, 1'b1);
    waitIdle();
    applyStimulus(1'b1, 8'h4B, 1, 1'b1);
    checkOutput("ctrl_4B", {flagen_A, flagen_B, load_B, load_A}, 4'b0111);
    checkOutput("ctrl_4B_noclr", {clr_flag_A, clr_flag_B}, 2'b00);
    waitIdle();
    applyStimulus(1'b1, 8'h80, 1, 1'b1);
    checkOutput("clr_pulse", {clr_flag_A, clr_flag_B}, 2'b11);
    @(negedge clk);
    checkOutput("clr_pulse_end", {clr_flag_A, clr_flag_B}, 2'b00);
    checkOutput("ctrl_80_kept", {flagen_A, flagen_B, load_B, load_A}, 4'b0111);
    #1;
    checkOutput("clr_A_count", clr_a_cnt, 1);
    checkOutput("clr_B_count", clr_b_cnt, 1);
    waitIdle();

    applyStimulus(1'b0, 8'h20, 1, 1'b1);
    waitIdle();
    wr_before = reg_wr_cnt;
    applyStimulus(1'b1, 8'h11, 10, 1'b1);
    waitIdle();
    checkOutput("held_strobe_writes", reg_wr_cnt - wr_before, 1);

    applyStimulus(1'b0, 8'h02, 1, 1'b1);
    measureBusy(5, t);
    pre = (bus.busy && cen) ? 1 : 0;
    wr_before = reg_wr_cnt;
`ifdef JTOPL_BUSY_DROP_EN
    applyStimulus(1'b1, 8'h3C, 1, 1'b0);
    checkOutput("drop_value_A", value_A, 8'hA5);
    measureBusy(1000, t);
    checkOutput("drop_wait_ticks", t, 7 - pre);
    waitIdle();
    checkOutput("drop_reg_wr", reg_wr_cnt - wr_before, 0);
`else
    applyStimulus(1'b1, 8'h3C, 1, 1'b1);
    checkOutput("busy_wr_value_A", value_A, 8'h3C);
    measureBusy(1000, t);
    checkOutput("reload_wait_ticks", t, 84);
    waitIdle();
    checkOutput("busy_wr_reg_wr", reg_wr_cnt - wr_before, 1);
`endif

    flag_A = 1'b1;
    irq_n  = 1'b0;
    checkOutput("dout_lag", bus.dout, 8'h06);
    @(negedge clk);
    checkOutput("dout_C6", bus.dout, 8'hC6);
    flag_B = 1'b1;
    @(negedge clk);
    checkOutput("dout_E6", bus.dout, 8'hE6);

    applyStimulus(1'b0, 8'h03, 1, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("pre_rst_busy", bus.busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_busy", bus.busy, 1'b0);
    checkOutput("async_rst_dout", bus.dout, 8'h00);
    checkOutput("async_rst_value_A", value_A, 8'h00);
    checkOutput("async_rst_flagen", {flagen_A, flagen_B}, 2'b11);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("post_rst_busy", bus.busy, 1'b0);
    checkOutput("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
